// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming SECDED scrubber.
//   ADDR_W / DATA_W / CW_W : array address width, data width, stored codeword width
//   DATA_POS               : Hamming position of each data bit d0..d7
//   hamming_encode()       : data -> 14-bit stored codeword (cw[0] reserved, 0)
//   scrub_state_e          : scrubber FSM states
//   dec_status_e           : decoder verdict (clean / corrected / uncorrectable)
package hamming_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CW_W   = 14;

  localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_CHECK   = 3'd3,
    ST_WB      = 3'd4,
    ST_NEXT    = 3'd5
  } scrub_state_e;

  typedef enum logic [1:0] {
    DEC_CLEAN = 2'd0,
    DEC_CE    = 2'd1,
    DEC_UE    = 2'd2
  } dec_status_e;

  function automatic logic [CW_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
    logic [CW_W-1:0] cw;
    logic [3:0]      syn;
    cw = '0;
    for (int k = 0; k < DATA_W; k++) cw[DATA_POS[k]] = data[k];
    // Syndrome of the data bits alone; parity bit 2^j takes syn[j] so the
    // full syndrome of the finished word becomes zero.
    syn = '0;
    for (int i = 1; i <= 12; i++) if (cw[i]) syn = syn ^ 4'(i);
    cw[1]  = syn[0];
    cw[2]  = syn[1];
    cw[4]  = syn[2];
    cw[8]  = syn[3];
    cw[13] = ^cw[12:1];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decoder for the 14-bit stored codeword.
//   cw_in    : raw codeword from the array (cw_in[0] reserved, ignored)
//   cw_out   : corrected codeword, reserved bit forced to 0
//   data_out : corrected data d0..d7
//   status   : dec_status_e value (clean / CE / UE)
module hamming_secded_dec
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]   cw_in,
  output logic [CW_W-1:0]   cw_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        status
);

  logic [3:0] syn;
  logic       par;

  always_comb begin
    syn = '0;
    for (int i = 1; i <= 12; i++) if (cw_in[i]) syn = syn ^ 4'(i);
  end

  assign par = ^cw_in[CW_W-1:1];

  always_comb begin
    cw_out = cw_in & ~CW_W'(1);
    status = DEC_CLEAN;
    if (par) begin
      if (syn == 4'd0) begin
        // Only the overall parity bit is wrong.
        cw_out[13] = ~cw_in[13];
        status     = DEC_CE;
      end else if (syn <= 4'd12) begin
        cw_out[syn] = ~cw_in[syn];
        status      = DEC_CE;
      end else begin
        // Syndrome points outside positions 1..12: odd-weight multi-bit error.
        status = DEC_UE;
      end
    end else if (syn != 4'd0) begin
      status = DEC_UE;
    end
  end

  always_comb begin
    data_out = '0;
    for (int k = 0; k < DATA_W; k++) data_out[k] = cw_out[DATA_POS[k]];
  end

endmodule

// File: rtl/hamming_scrubber.sv
// Background SECDED scrubber for the 256x14 codeword array.
// Walks every address, reads the codeword, writes back single-bit
// corrections and logs uncorrectable words. Yields the port whenever
// host_busy is high.
//   clk, rst (async, active low), start (pass request pulse), host_busy
//   mem_en/mem_we/mem_addr/mem_wdata : scrubber side of the array port
//   mem_rdata : read data, valid the cycle after a read request
//   busy, done (pulse), ue_flag (pulse), ue_addr, ce_count, ue_count
//   dbg_state : current FSM state, dbg_data : corrected data of held word
// Port handshake: host_busy=1 means the host owns the port this cycle; the
// scrubber then drives mem_en=0 and no transfer of its own happens. Any
// cycle with mem_en=1 is a completed access.
module hamming_scrubber
  import hamming_pkg::*;
#(
  parameter int INTERVAL = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              host_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CW_W-1:0]   mem_wdata,
  input  logic [CW_W-1:0]   mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              ue_flag,
  output logic [ADDR_W-1:0] ue_addr,
  output logic [15:0]       ce_count,
  output logic [15:0]       ue_count,
  output logic [2:0]        dbg_state,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int TMR_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (INTERVAL > 0) ? TMR_W'(INTERVAL - 1) : '0;

  scrub_state_e      state, state_d;
  logic [ADDR_W-1:0] addr;
  logic [TMR_W-1:0]  timer;
  logic [CW_W-1:0]   rdata_q;
  logic [CW_W-1:0]   dec_cw;
  logic [DATA_W-1:0] dec_data;
  logic [1:0]        dec_status;
  logic              auto_go;
  logic              last_addr;

  hamming_secded_dec u_dec (
    .cw_in    (rdata_q),
    .cw_out   (dec_cw),
    .data_out (dec_data),
    .status   (dec_status)
  );

  assign auto_go   = (INTERVAL > 0) && (timer == TMR_LAST);
  assign last_addr = (addr == '1);
  assign dbg_state = state;
  assign dbg_data  = dec_data;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (start || auto_go) state_d = ST_RD_REQ;
      ST_RD_REQ:  if (!host_busy) state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = host_busy ? ST_RD_REQ : ST_CHECK;
      ST_CHECK:   state_d = (dec_status == DEC_CE) ? ST_WB : ST_NEXT;
      ST_WB:      if (!host_busy) state_d = ST_NEXT;
      ST_NEXT:    state_d = last_addr ? ST_IDLE : ST_RD_REQ;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    ue_flag   = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_RD_REQ: begin
        if (!host_busy) begin
          mem_en   = 1'b1;
          mem_addr = addr;
        end
      end
      ST_CHECK: ue_flag = (dec_status == DEC_UE);
      ST_WB: begin
        if (!host_busy) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr;
          mem_wdata = dec_cw;
        end
      end
      ST_NEXT: done = last_addr;
      default: ;
    endcase
  end

  // Datapath: address walk, interval timer, captured word, error log
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr     <= '0;
      timer    <= '0;
      rdata_q  <= '0;
      ue_addr  <= '0;
      ce_count <= '0;
      ue_count <= '0;
    end else begin
      if (state == ST_IDLE) begin
        timer <= (state_d == ST_RD_REQ) ? '0 : timer + 1'b1;
      end else begin
        timer <= '0;
      end

      if (state == ST_RD_WAIT && !host_busy) rdata_q <= mem_rdata;

      if (state == ST_CHECK) begin
        if (dec_status == DEC_CE && ce_count != 16'hFFFF) ce_count <= ce_count + 16'd1;
        if (dec_status == DEC_UE) begin
          ue_addr <= addr;
          if (ue_count != 16'hFFFF) ue_count <= ue_count + 16'd1;
        end
      end

      if (state == ST_NEXT) addr <= last_addr ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: doc/hamming_scrubber.md
Name: hamming_scrubber

Overview:
- Background scrubber and initiator for the Hamming-protected 256x8 SRAM, driving the raw codeword port of the memory array.
- Walks the array from address 0 to 2^ADDR_W-1 and decodes each stored codeword with SECDED.
- Single-bit errors: writes the corrected codeword back. Double-bit errors: counted and the address logged.
- Yields the port to the host datapath whenever the host is active.

Parameters:
ADDR_W, 8, address width; the array holds 2^ADDR_W words
DATA_W, 8, data bits per word
CW_W, 14, stored codeword width
INTERVAL, 1024, clock cycles between automatic passes; 0 disables auto start

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse requesting a full pass; ignored while busy
host_busy  in  1  host owns the memory port this cycle
mem_en  out  1  memory port enable (scrubber side)
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  CW_W  codeword to write
mem_rdata  in  CW_W  codeword read; valid one cycle after a read request
busy  out  1  a pass is in progress
done  out  1  one-cycle pulse when a pass completes
ue_flag  out  1  one-cycle pulse on an uncorrectable error
ue_addr  out  ADDR_W  address of the last uncorrectable error
ce_count  out  16  corrected-error count, saturating at 0xFFFF
ue_count  out  16  uncorrectable-error count, saturating at 0xFFFF

Behaviour:
- Reset value of every output is 0. Reset also sets FSM=IDLE, address counter=0, interval timer=0.
- Reset mid-pass aborts the pass immediately; no partial write completes after rst deasserts.
- Codeword layout:
  - cw[12:1] hold Hamming positions 1..12.
  - Parity bits sit at positions 1, 2, 4 and 8.
  - Data d0..d7 sit at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - cw[13] is overall even parity over cw[12:1].
  - cw[0] is reserved and written as 0; it is ignored on decode.
- Decode:
  - syn = XOR of the positions of set bits in 1..12; par = XOR of cw[13:1].
  - syn=0 and par=0: clean.
  - par=1: single error. If syn!=0, flip position syn; if syn=0, flip cw[13]. Counts as a CE.
  - syn!=0 and par=0: double error (UE).
- FSM states: IDLE, RD_REQ, RD_WAIT, CHECK, WB, NEXT.
  - IDLE: a start pulse, or the interval timer reaching INTERVAL-1, moves to RD_REQ and sets busy=1. Start has priority; the timer clears on any entry to RD_REQ from IDLE.
  - RD_REQ: when host_busy=0, drive mem_en=1, mem_we=0, mem_addr=addr, then go to RD_WAIT. When host_busy=1, hold with mem_en=0.
  - RD_WAIT: register mem_rdata, go to CHECK. If host_busy=1 here, discard the data and return to RD_REQ for the same address.
  - CHECK:
    - Clean: go to NEXT.
    - CE: ce_count += 1 (saturating), go to WB.
    - UE: ue_count += 1 (saturating), ue_addr=addr, ue_flag=1 for this cycle, go to NEXT without writing.
  - WB: when host_busy=0, drive mem_en=1, mem_we=1, mem_wdata=corrected codeword, then go to NEXT. While host_busy=1, hold. CE is counted once, even if WB stalls.
  - NEXT: if addr=2^ADDR_W-1, set addr=0, done=1 for one cycle, busy=0, go to IDLE. Otherwise addr+=1 and go to RD_REQ.
- mem_en=0 in every state and cycle not listed above.
- Minimum pass latency: 4 cycles per clean word, 5 per corrected word.

Decomposition:
- Package hamming_pkg:
  - ADDR_W, DATA_W and CW_W constants.
  - The data-position map.
  - Function hamming_encode(data) returning a codeword.
  - Typedef for the FSM state enum.
  - Typedef for the decode status: CLEAN, CE, UE.
- Sub-module hamming_secded_dec:
  - Combinational; input cw, outputs corrected cw, corrected data, status.
  - The read-path decoder reuses the same sub-module.

Test Plan:
- Clean pass: preload all 256 words with hamming_encode(addr[7:0]), pulse start. Required: done exactly 4*256 cycles after the first RD_REQ, no mem_we, ce_count=0, ue_count=0.
- Single error: mem[20]=0x2684 (0x3C codeword 0x26C4 with bit 6 flipped). Required: one write of 0x26C4 to addr 20, ce_count=1, and a host read of address 20 returns 0x3C.
- Overall-parity error: mem[10]=encode(0xA5) with bit 13 flipped. Required: writeback restores bit 13, ce_count increments.
- Double error: mem[40]=0x2484 (bits 6 and 9 flipped). Required: ue_flag pulses, ue_addr=40, ue_count=1, no write to addr 40, mem[40] unchanged.
- Host contention: hold host_busy=1 for 10 cycles during RD_WAIT at addr 50. Required: mem_en=0 while host_busy=1, then a re-read of addr 50, with no skipped or duplicated counts.
- Reset mid-WB: deassert rst in the WB state with host_busy=1. Required: all outputs 0, FSM=IDLE, no write after release. Also: INTERVAL=16 auto-starts a pass 16 cycles after reset.
